// File: rtl/mem_arbiter.sv
// Data-RAM arbiter: CPU (scalar / LANES-word vector) vs external port, CPU priority with starvation guard.
// Optional performance counters are compiled in with `define MEM_ARB_PERF_EN.
module mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int LANES    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_vec,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [LANES*32-1:0]   cpu_wdata,
  output logic [LANES*32-1:0]   cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_W-1:0]     ext_addr,
  input  logic [31:0]           ext_wdata,
  output logic [31:0]           ext_rdata,
  output logic                  ext_ack,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_cpu_grants,
  output logic [31:0]           perf_ext_grants,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_BEAT, EXT_BEAT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  sel_ext_q, sel_ext_d;
  logic                  vec_q, vec_d;
  logic [LANES*32-1:0]   wdata_q, wdata_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [7:0]            wait_q, wait_d;
  logic [LANES*32-1:0]   rdata_q, rdata_d;
  logic [31:0]           ext_rdata_q, ext_rdata_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;

  logic                  cpu_grant, ext_grant;
  logic [BEAT_W-1:0]     last_beat, beat_prev, beat_nxt;
  logic [31:0]           wlane [LANES];

  assign last_beat = vec_q ? BEAT_W'(LANES - 1) : '0;
  assign beat_prev = beat_q - 1'b1;
  assign beat_nxt  = beat_q + 1'b1;

  // Lane i is captured one cycle after its beat; the last lane lands in DRAIN
  // and is forwarded straight from the RAM so it is valid alongside the ack.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic cap_beat, cap_drain;
    assign wlane[gi]  = wdata_q[32*gi +: 32];
    assign cap_beat   = (state_q == CPU_BEAT) && (beat_q != '0) && (beat_prev == BEAT_W'(gi));
    assign cap_drain  = (state_q == DRAIN) && !sel_ext_q && (last_beat == BEAT_W'(gi));
    assign rdata_d[32*gi +: 32]   = cpu_grant ? 32'h0 :
                                    (cap_beat || cap_drain) ? mem_rdata : rdata_q[32*gi +: 32];
    assign cpu_rdata[32*gi +: 32] = cap_drain ? mem_rdata : rdata_q[32*gi +: 32];
  end

  always_comb begin
    state_d     = state_q;
    sel_ext_d   = sel_ext_q;
    vec_d       = vec_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    ext_rdata_d = ext_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    cpu_grant   = 1'b0;
    ext_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req && (!ext_req || (wait_q < MAX_WAIT_C))) cpu_grant = 1'b1;
        else if (ext_req)                                   ext_grant = 1'b1;

        if (cpu_grant) begin
          state_d     = CPU_BEAT;
          sel_ext_d   = 1'b0;
          vec_d       = cpu_vec;
          wdata_d     = cpu_wdata;
          beat_d      = '0;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata[31:0];
          mem_we_d    = cpu_we;
        end else if (ext_grant) begin
          state_d     = EXT_BEAT;
          sel_ext_d   = 1'b1;
          mem_addr_d  = ext_addr;
          mem_wdata_d = ext_wdata;
          mem_we_d    = ext_we;
        end
      end
      CPU_BEAT: begin
        if (beat_q == last_beat) begin
          state_d  = DRAIN;
          mem_we_d = 1'b0;
        end else begin
          beat_d      = beat_nxt;
          mem_addr_d  = mem_addr_q + 1'b1;
          mem_wdata_d = wlane[beat_nxt];
        end
      end
      EXT_BEAT: begin
        state_d  = DRAIN;
        mem_we_d = 1'b0;
      end
      DRAIN: begin
        state_d = IDLE;
        if (sel_ext_q) ext_rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter runs in every state so CPU transactions count as waiting.
  always_comb begin
    wait_d = wait_q;
    if (!ext_req || ext_grant)  wait_d = 8'h00;
    else if (wait_q != 8'hFF)   wait_d = wait_q + 8'h01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_ext_q   <= 1'b0;
      vec_q       <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      wait_q      <= 8'h00;
      rdata_q     <= '0;
      ext_rdata_q <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_ext_q   <= sel_ext_d;
      vec_q       <= vec_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      ext_rdata_q <= ext_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_ack   = (state_q == DRAIN) && !sel_ext_q;
  assign ext_ack   = (state_q == DRAIN) && sel_ext_q;
  assign ext_rdata = ext_ack ? mem_rdata : ext_rdata_q;
  assign busy      = (state_q != IDLE);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_cpu_q, perf_ext_q, perf_stall_q;
  logic        cpu_own;

  assign cpu_own = (state_q == CPU_BEAT) || ((state_q == DRAIN) && !sel_ext_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cpu_q   <= 32'h0;
      perf_ext_q   <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (cpu_grant)                         perf_cpu_q   <= perf_cpu_q + 32'h1;
      if (ext_grant)                         perf_ext_q   <= perf_ext_q + 32'h1;
      if (cpu_req && !cpu_grant && !cpu_own) perf_stall_q <= perf_stall_q + 32'h1;
    end
  end

  assign perf_cpu_grants   = perf_cpu_q;
  assign perf_ext_grants   = perf_ext_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
